pipelined_decode_stage: RTL and testbench
=========================================

Name: pipelined_decode_stage

Overview:
- Parametrised instruction-decode stage for the pipelined CHARIS datapath; successor to the single-cycle decode block.
- Contains a register file with write-through bypass and a decoder for the immediate-extension and B-operand selection, both driven by the opcode; neither is a control input.
- Also contains load-use hazard detection and a registered ID/EX output with valid, stall and flush.
- Sits between the IF/ID register and the EX stage; write-back enters through a dedicated port.

Parameters:
- DATA_W, 32, register/operand/immediate width (≥16)
- REG_COUNT, 32, number of registers (2..32); register 0 hardwired to zero
- ADDR_W, 5, register address width; fixed by instruction fields

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous reset, active-high
- in_valid  in  1  Instr holds a real instruction
- Instr  in  32  opcode[31:26], rs[25:21], rd[20:16], rt[15:11], imm[15:0]
- stall_in  in  1  EX backpressure; hold the ID/EX register
- flush  in  1  kill the instruction being loaded (branch taken)
- wb_en  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back data
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_load  in  1  EX instruction is lb/lw
- ex_rd  in  ADDR_W  EX destination register
- hazard_stall  out  1  combinational; fetch must hold PC and IF/ID
- id_valid  out  1  registered; outputs below are meaningful
- id_opcode  out  6  registered opcode
- id_rd  out  ADDR_W  registered destination register
- Immed  out  DATA_W  registered extended immediate
- RF_A  out  DATA_W  registered rs operand
- RF_B  out  DATA_W  registered B operand

Behaviour:
- Reset:
  - Clears all REG_COUNT registers to 0.
  - Clears id_valid, id_opcode, id_rd, Immed, RF_A and RF_B to 0.
  - Rst overrides wb_en, stall_in and flush.
- Register file:
  - Writes when wb_en is high and wb_addr ≠ 0 and wb_addr < REG_COUNT; all other writes are dropped.
  - Reads of address 0 or address ≥ REG_COUNT return 0.
  - Write-through: a same-cycle read of wb_addr (nonzero, wb_en high) returns wb_data.
- B-operand address:
  - rd for sw, sb, beq and bne.
  - rt for all other opcodes.
- Immediate extension, by opcode:
  - sign-extend: addi 110000, li 111000, lb 000011, lw 001111, sb 000111, sw 011111
  - zero-fill: andi 110010, ori 110011
  - imm<<16, lower bits zero: lui 111001
  - sign-extend then <<2: b 111111, beq 010000, bne 010001
  - R-type 100000 and unknown opcodes: 0
- hazard_stall is high when all of these hold:
  - in_valid, ex_valid and ex_is_load are high;
  - ex_rd ≠ 0;
  - ex_rd equals rs, or the instruction reads B and ex_rd equals the B address.
  - "Reads B" means R-type, sw, sb, beq or bne.
  - hazard_stall is forced low when flush is high.
- ID/EX register update, in priority order:
  - Rst: clear.
  - flush: id_valid←0; the other fields are don't-care.
  - stall_in: hold every field. Operand refresh applies: if wb_en writes the held rs or B address (nonzero), RF_A/RF_B load wb_data.
  - hazard_stall: bubble, id_valid←0.
  - Otherwise: load the decoded fields; id_valid←in_valid.
- Held rs and B addresses are stored internally for the operand refresh.
- Latency: 1 cycle from Instr to outputs. Throughput: 1 instruction per cycle without stalls.
- A stall_in and hazard in the same cycle hold the register; hazard_stall stays asserted while the hazard persists.
- Reset during a stall or hazard returns to the empty state next cycle.

Decomposition:
- decode_pkg:
  - opcode constants
  - immediate-mode enum (SEXT, ZFILL, HI16, BR)
  - B-select encoding
- Sub-module regfile_wt: parametrised register file with 2 read ports, 1 write port and write-through.
- Top level holds the decoder, hazard logic and ID/EX register.

Test Plan:
- Reset then write r1..r31 with value i via wb_en → addi with rs=5 gives RF_A=5 one cycle later; rs=0 gives RF_A=0; a write to r0 is ignored.
- Instr=0xC0851234 (addi, rs=4), wb_en writing r4=0xAA the same cycle → next cycle RF_A=0xAA, Immed=0x00001234; with imm=0x8004 → Immed=0xFFFF8004.
- lui imm 0x8004 → Immed 0x80040000. ori imm 0x8004 → Immed 0x00008004. beq imm 0xFFFF → Immed 0xFFFFFFFC, with RF_B taken from rd.
- ex_valid=1, ex_is_load=1, ex_rd=3, Instr R-type rt=3 → hazard_stall=1 and id_valid=0 next cycle. The same case with ex_rd=0 gives no stall.
- stall_in high for 3 cycles holding rs=7, wb writes r7=0x55 in cycle 2 → outputs held and RF_A becomes 0x55. flush in the same cycle as stall_in gives id_valid=0.
- Assert Rst mid-stream with in_valid=1 → all outputs 0 next cycle and r1..r31 read as 0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, immediate modes and B-operand selection for the decode stage
package decode_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;

  typedef enum logic [2:0] {IMM_SEXT, IMM_ZFILL, IMM_HI16, IMM_BR, IMM_ZERO} imm_mode_e;
  typedef enum logic {BSEL_RT, BSEL_RD} bsel_e;

  function automatic imm_mode_e imm_mode(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_LI, OP_LB, OP_LW, OP_SB, OP_SW: return IMM_SEXT;
      OP_ANDI, OP_ORI:                            return IMM_ZFILL;
      OP_LUI:                                     return IMM_HI16;
      OP_B, OP_BEQ, OP_BNE:                       return IMM_BR;
      default:                                    return IMM_ZERO;
    endcase
  endfunction

  function automatic bsel_e b_sel(input logic [5:0] op);
    return (op == OP_SW || op == OP_SB || op == OP_BEQ || op == OP_BNE) ? BSEL_RD : BSEL_RT;
  endfunction

  function automatic logic reads_b(input logic [5:0] op);
    return b_sel(op) == BSEL_RD || op == OP_RTYPE;
  endfunction
endpackage

// File: rtl/regfile_wt.sv
// regfile_wt: register file with two read ports, one write port and write-through bypass
module regfile_wt #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [ADDR_W-1:0] i_ra_a,
  input  logic [ADDR_W-1:0] i_ra_b,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(REG_COUNT);
  logic [DATA_W-1:0] r_mem [REG_COUNT];
  logic w_we;
  assign w_we = i_we && i_wa != '0 && {1'b0, i_wa} < LIMIT;
  // address 0 and out-of-range addresses read as zero regardless of storage
  assign o_rd_a = (i_ra_a == '0 || {1'b0, i_ra_a} >= LIMIT) ? '0 :
                  (w_we && i_wa == i_ra_a) ? i_wd : r_mem[i_ra_a];
  assign o_rd_b = (i_ra_b == '0 || {1'b0, i_ra_b} >= LIMIT) ? '0 :
                  (w_we && i_wa == i_ra_b) ? i_wd : r_mem[i_ra_b];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end
endmodule

// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage: decode, register read, load-use hazard detection and ID/EX register
module pipelined_decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  input  logic [31:0]       Instr,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_rd,
  output logic              hazard_stall,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [ADDR_W-1:0] id_rd,
  output logic [DATA_W-1:0] Immed,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(REG_COUNT);
  logic [5:0]        w_op;
  logic [ADDR_W-1:0] w_rs, w_rd, w_rt, w_baddr;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_sext, w_zext, w_immed, w_rf_a, w_rf_b;
  imm_mode_e         w_mode;
  logic              w_wb_ok;
  logic              r_valid;
  logic [5:0]        r_op;
  logic [ADDR_W-1:0] r_rd, r_rs_addr, r_b_addr;
  logic [DATA_W-1:0] r_imm, r_a, r_b;
  assign w_op    = Instr[31:26];
  assign w_rs    = Instr[25:21];
  assign w_rd    = Instr[20:16];
  assign w_rt    = Instr[15:11];
  assign w_imm   = Instr[15:0];
  assign w_baddr = b_sel(w_op) == BSEL_RD ? w_rd : w_rt;
  assign w_mode  = imm_mode(w_op);
  assign w_sext  = DATA_W'($signed(w_imm));
  assign w_zext  = DATA_W'(w_imm);
  assign w_immed = w_mode == IMM_SEXT  ? w_sext :
                   w_mode == IMM_ZFILL ? w_zext :
                   w_mode == IMM_HI16  ? w_zext << 16 :
                   w_mode == IMM_BR    ? w_sext << 2 : '0;
  assign w_wb_ok = wb_en && wb_addr != '0 && {1'b0, wb_addr} < LIMIT;
  assign hazard_stall = !flush && in_valid && ex_valid && ex_is_load && ex_rd != '0 &&
                        (ex_rd == w_rs || (reads_b(w_op) && ex_rd == w_baddr));
  regfile_wt #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .ADDR_W(ADDR_W)) u_rf (
    .clk(Clk), .rst(Rst), .i_we(wb_en), .i_wa(wb_addr), .i_wd(wb_data),
    .i_ra_a(w_rs), .i_ra_b(w_baddr), .o_rd_a(w_rf_a), .o_rd_b(w_rf_b)
  );
  // a held instruction keeps tracking write-backs to its source registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_valid   <= 1'b0;
      r_op      <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rs_addr <= '0;
      r_b_addr  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (stall_in) begin
      if (w_wb_ok && wb_addr == r_rs_addr) r_a <= wb_data;
      if (w_wb_ok && wb_addr == r_b_addr) r_b <= wb_data;
    end else if (hazard_stall) begin
      r_valid <= 1'b0;
    end else begin
      r_valid   <= in_valid;
      r_op      <= w_op;
      r_rd      <= w_rd;
      r_imm     <= w_immed;
      r_a       <= w_rf_a;
      r_b       <= w_rf_b;
      r_rs_addr <= w_rs;
      r_b_addr  <= w_baddr;
    end
  end
  assign id_valid  = r_valid;
  assign id_opcode = r_op;
  assign id_rd     = r_rd;
  assign Immed     = r_imm;
  assign RF_A      = r_a;
  assign RF_B      = r_b;
endmodule

// File: tb/tb_pipelined_decode_stage.sv
// tb_pipelined_decode_stage: directed checks of decode, bypass, hazard, stall/flush and reset
module tb_pipelined_decode_stage;
  logic        Clk = 1'b0;
  logic        Rst, in_valid, stall_in, flush, wb_en, ex_valid, ex_is_load;
  logic [31:0] Instr, wb_data;
  logic [4:0]  wb_addr, ex_rd;
  logic        hazard_stall, id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [31:0] Immed, RF_A, RF_B;
  int checks = 0;
  int errors = 0;

  pipelined_decode_stage dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .Instr(Instr), .stall_in(stall_in),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .hazard_stall(hazard_stall), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .Immed(Immed), .RF_A(RF_A), .RF_B(RF_B)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rd, input logic [15:0] imm);
    return {op, rs, rd, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1; in_valid = 0; Instr = 0; stall_in = 0; flush = 0; wb_en = 0;
    wb_addr = 0; wb_data = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0;
    tick(); tick();
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_imm", Immed, 0);
    chk("rst_a", RF_A, 0);
    chk("rst_b", RF_B, 0);
    Rst = 0;
    for (int i = 1; i < 32; i++) begin
      wb_en = 1; wb_addr = 5'(i); wb_data = i; tick();
    end
    wb_addr = 0; wb_data = 32'hDEAD; tick();
    wb_en = 0;
    in_valid = 1; Instr = mk(6'b110000, 5, 1, 16'h0010); tick();
    chk("addi_rs5_a", RF_A, 5);
    chk("addi_valid", 32'(id_valid), 1);
    chk("addi_op", 32'(id_opcode), 32'h30);
    chk("addi_rd", 32'(id_rd), 1);
    chk("addi_imm", Immed, 32'h10);
    Instr = mk(6'b110000, 0, 1, 16'h0010); tick();
    chk("addi_rs0_a", RF_A, 0);
    // r4 overwritten in the same cycle it is read
    Instr = 32'hC0851234; wb_en = 1; wb_addr = 4; wb_data = 32'hAA; tick();
    wb_en = 0;
    chk("bypass_a", RF_A, 32'hAA);
    chk("bypass_imm", Immed, 32'h00001234);
    chk("bypass_b_rt2", RF_B, 2);
    Instr = mk(6'b110000, 1, 1, 16'h8004); tick();
    chk("addi_sext", Immed, 32'hFFFF8004);
    chk("addi_b_rt16", RF_B, 16);
    Instr = mk(6'b111001, 1, 1, 16'h8004); tick();
    chk("lui_imm", Immed, 32'h80040000);
    Instr = mk(6'b110011, 1, 1, 16'h8004); tick();
    chk("ori_imm", Immed, 32'h00008004);
    Instr = mk(6'b010000, 1, 9, 16'hFFFF); tick();
    chk("beq_imm", Immed, 32'hFFFFFFFC);
    chk("beq_b_rd", RF_B, 9);
    chk("beq_a", RF_A, 1);
    Instr = mk(6'b100000, 5, 1, 16'h0000); tick();
    chk("rtype_imm", Immed, 0);
    ex_valid = 1; ex_is_load = 1; ex_rd = 3;
    Instr = mk(6'b100000, 1, 4, 16'h1800); #1;
    chk("haz_rt", 32'(hazard_stall), 1);
    tick();
    chk("haz_bubble", 32'(id_valid), 0);
    Instr = mk(6'b110000, 1, 4, 16'h1800); #1;
    chk("haz_addi_no_b", 32'(hazard_stall), 0);
    Instr = mk(6'b110000, 3, 4, 16'h0000); #1;
    chk("haz_rs", 32'(hazard_stall), 1);
    flush = 1; #1;
    chk("haz_flush_low", 32'(hazard_stall), 0);
    flush = 0; ex_rd = 0; Instr = mk(6'b100000, 1, 4, 16'h1800); #1;
    chk("haz_rd0", 32'(hazard_stall), 0);
    tick();
    chk("haz_rd0_valid", 32'(id_valid), 1);
    chk("haz_rd0_b", RF_B, 3);
    ex_valid = 0; ex_is_load = 0;
    Instr = mk(6'b110000, 7, 2, 16'h0042); tick();
    chk("pre_stall_a", RF_A, 7);
    stall_in = 1; Instr = mk(6'b110011, 2, 6, 16'h0099); tick();
    chk("stall1_a", RF_A, 7);
    chk("stall1_imm", Immed, 32'h42);
    wb_en = 1; wb_addr = 7; wb_data = 32'h55; tick();
    wb_en = 0;
    chk("stall2_refresh", RF_A, 32'h55);
    chk("stall2_rd", 32'(id_rd), 2);
    tick();
    chk("stall3_a", RF_A, 32'h55);
    chk("stall3_valid", 32'(id_valid), 1);
    chk("stall3_op", 32'(id_opcode), 32'h30);
    flush = 1; tick();
    chk("stall_flush", 32'(id_valid), 0);
    flush = 0; stall_in = 0;
    Instr = mk(6'b110000, 9, 3, 16'h0042); tick();
    chk("pre_rst_valid", 32'(id_valid), 1);
    Rst = 1; wb_en = 1; wb_addr = 3; wb_data = 32'h77; tick();
    wb_en = 0;
    chk("mid_rst_valid", 32'(id_valid), 0);
    chk("mid_rst_imm", Immed, 0);
    chk("mid_rst_a", RF_A, 0);
    chk("mid_rst_rd", 32'(id_rd), 0);
    Rst = 0;
    for (int i = 1; i < 32; i++) begin
      Instr = mk(6'b110000, 5'(i), 1, 16'h0000); tick();
      chk($sformatf("cleared_r%0d", i), RF_A, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
